tictactoe_auto_player: RTL



---
 rtl/tictactoe_auto_player.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tictactoe_auto_player.sv
// tictactoe_auto_player: fixed-priority automated opponent driving row/column/enter of the game engine.
// Optional TICTACTOE_AUTO_PLAYER_RANDOM_EN: LFSR-rotated start offset for corner/edge scans.
module tictactoe_auto_player #(
  parameter logic [1:0] PLAYER_SIDE = 2'b10,
  parameter int SETUP_CYCLES = 1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] winner,
  output logic [1:0] row,
  output logic [1:0] column,
  output logic       enter,
  output logic       busy,
  output logic       err,
  output logic [2:0] moves
);
  typedef enum logic [2:0] {WAIT_TURN, EVAL, SETUP, PULSE, WAIT_ACK, DONE} state_t;
  localparam logic [1:0] OPP = PLAYER_SIDE ^ 2'b11;
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [11:0] LINES [8] = '{12'h012, 12'h345, 12'h678, 12'h036,
                                        12'h147, 12'h258, 12'h048, 12'h246};
  localparam logic [15:0] CORNERS = 16'h0268;
  localparam logic [15:0] EDGES = 16'h1357;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] cell_q, cell_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic enter_q, enter_d, busy_q, busy_d, err_q, err_d;
  logic [2:0] moves_q, moves_d;
  logic [17:0] brd;
  logic [3:0] nx, no, pick;
  logic [4:0] win, blk, cor, edg;
  logic [1:0] pick_row, pick_col, off;
  logic any_empty, our_turn, acked;

  assign brd = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  function automatic logic [1:0] get_cell(input logic [17:0] b, input logic [3:0] i);
    return b[{i, 1'b0} +: 2];
  endfunction

  // Lines scanned last-to-first so the earliest line in the order wins.
  function automatic logic [4:0] scan_lines(input logic [17:0] b, input logic [1:0] side);
    logic [4:0] r;
    logic [3:0] e, idx;
    int n_s, n_e;
    r = '0;
    for (int l = 7; l >= 0; l--) begin
      n_s = 0;
      n_e = 0;
      e = '0;
      for (int k = 0; k < 3; k++) begin
        idx = LINES[l][4*k +: 4];
        if (get_cell(b, idx) == side) n_s++;
        else if (get_cell(b, idx) == 2'b00) begin
          n_e++;
          e = idx;
        end
      end
      if (n_s == 2 && n_e == 1) r = {1'b1, e};
    end
    return r;
  endfunction

  function automatic logic [4:0] scan_list(input logic [17:0] b, input logic [15:0] list,
                                           input logic [1:0] o);
    logic [4:0] r;
    logic [3:0] idx;
    logic [1:0] p;
    r = '0;
    for (int j = 3; j >= 0; j--) begin
      p = 2'(j) + o;
      idx = list[{~p, 2'b00} +: 4];
      if (get_cell(b, idx) == 2'b00) r = {1'b1, idx};
    end
    return r;
  endfunction

`ifdef TICTACTOE_AUTO_PLAYER_RANDOM_EN
  logic [7:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  always_ff @(posedge clk) lfsr_q <= rst ? 8'hA5 : lfsr_d;
  assign off = lfsr_q[1:0];
`else
  assign off = 2'd0;
`endif

  always_comb begin
    nx = '0;
    no = '0;
    any_empty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      nx += 4'(brd[2*i +: 2] == 2'b01);
      no += 4'(brd[2*i +: 2] == 2'b10);
      any_empty |= brd[2*i +: 2] == 2'b00;
    end
    our_turn = (PLAYER_SIDE == 2'b01) ? (nx == no) : (nx == no + 4'd1);
    acked = get_cell(brd, cell_q) == PLAYER_SIDE;
    win = scan_lines(brd, PLAYER_SIDE);
    blk = scan_lines(brd, OPP);
    cor = scan_list(brd, CORNERS, off);
    edg = scan_list(brd, EDGES, off);
    pick = win[4] ? win[3:0] : blk[4] ? blk[3:0] : (get_cell(brd, 4'd4) == 2'b00) ? 4'd4 :
           cor[4] ? cor[3:0] : edg[3:0];
    pick_row = (pick >= 4'd6) ? 2'd2 : (pick >= 4'd3) ? 2'd1 : 2'd0;
    pick_col = 2'(pick - 4'(pick_row) * 4'd3);
  end

  always_comb begin
    state_d = state_q;
    cell_d = cell_q;
    row_d = row_q;
    col_d = col_q;
    err_d = err_q;
    moves_d = moves_q;
    if (winner != 2'b00) state_d = DONE;
    else if (state_q == WAIT_TURN && en && our_turn && any_empty) state_d = EVAL;
    else if (state_q == EVAL) begin
      state_d = SETUP;
      cell_d = pick;
      row_d = pick_row;
      col_d = pick_col;
    end
    else if (state_q == SETUP && cnt_q == SETUP_LAST) state_d = PULSE;
    else if (state_q == PULSE) state_d = WAIT_ACK;
    else if (state_q == WAIT_ACK && acked) begin
      state_d = WAIT_TURN;
      moves_d = (moves_q == 3'd5) ? 3'd5 : moves_q + 3'd1;
    end
    else if (state_q == WAIT_ACK && cnt_q == ACK_LAST) begin
      state_d = WAIT_TURN;
      err_d = 1'b1;
    end
    cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    enter_d = state_d == PULSE;
    busy_d = state_d != WAIT_TURN && state_d != DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_TURN;
      cnt_q <= '0;
      cell_q <= '0;
      row_q <= '0;
      col_q <= '0;
      enter_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      moves_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cell_q <= cell_d;
      row_q <= row_d;
      col_q <= col_d;
      enter_q <= enter_d;
      busy_q <= busy_d;
      err_q <= err_d;
      moves_q <= moves_d;
    end
  end

  assign row = row_q;
  assign column = col_q;
  assign enter = enter_q;
  assign busy = busy_q;
  assign err = err_q;
  assign moves = moves_q;
endmodule
